math_seed_tbl_pipe: RTL and testbench

- Parametrised, pipelined seed/lookup table for the FP math unit; supplies initial approximations for reciprocal, reciprocal-sqrt and small-exponent modes.
- Derives a table index from the operand's exponent/mantissa bits and the mode, then reads a registered RAM behind a valid/ready handshake.
- Has a separate table-load write port and a reset-time clearing sweep.
- Sits between the operand-unpack stage and the Newton iteration datapath.

---
 rtl/math_seed_tbl_pipe.sv | 149 ++++++++++++++
 tb/tb_math_seed_tbl_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/math_seed_tbl_pipe.sv
// rtl/math_seed_tbl_pipe.sv - pipelined seed/lookup table for the FP math unit; optional parity via MATH_TBL_PARITY_EN
module math_seed_tbl_pipe #(
    parameter int DATA_W   = 68,
    parameter int IDX_W    = 6,
    parameter int EXP_HI   = 65,
    parameter int EXP_BASE = 2044
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [1:0]          in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    input  logic                wr_en,
    output logic                wr_ready,
    input  logic [IDX_W+1:0]    wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
`ifdef MATH_TBL_PARITY_EN
    output logic                par_err,
    input  logic                wr_par_flip,
`endif
    output logic                busy
);

    localparam int AW    = IDX_W + 2;
    localparam int DEPTH = 4 << IDX_W;
`ifdef MATH_TBL_PARITY_EN
    localparam int MW    = DATA_W + 1;
`else
    localparam int MW    = DATA_W;
`endif

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q;
    logic [AW-1:0]       cnt_q;
    logic                busy_q;
    logic                s0_valid_q;
    logic [AW-1:0]       s0_addr_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
`ifdef MATH_TBL_PARITY_EN
    logic                par_err_q;
`endif

    logic [MW-1:0]       mem [DEPTH];

    logic [11:0]         exp_f;
    logic [IDX_W-1:0]    man_f;
    logic [IDX_W-1:0]    idx_d;
    logic [AW-1:0]       req_addr_d;
    logic                adv;
    logic                run;
    logic                wr_fire;
    logic [MW-1:0]       wr_word;
    logic [MW-1:0]       s1_word;
    logic                unused_a;

    assign exp_f    = in_a[EXP_HI -: 12];
    assign man_f    = in_a[EXP_HI-12 -: IDX_W];
    assign unused_a = ^in_a;

    // Small-exponent ladder: exponent EXP_BASE+k selects the top k+1 mantissa bits.
    always_comb begin
        idx_d = '0;
        case (in_mode)
            2'd0: idx_d = man_f;
            2'd1: idx_d = {exp_f[0], man_f[IDX_W-1:1]};
            default: begin
                for (int k = 0; k < IDX_W; k++) begin
                    if (int'(exp_f) == EXP_BASE + k) begin
                        idx_d = man_f >> (IDX_W - 1 - k);
                    end
                end
            end
        endcase
    end

    assign req_addr_d = {idx_d, in_mode};

    assign run      = (state_q == ST_RUN) && !rst;
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = run && adv;
    assign wr_ready = run;
    assign wr_fire  = wr_en && wr_ready;

`ifdef MATH_TBL_PARITY_EN
    assign wr_word = {(^wr_data) ^ wr_par_flip, wr_data};
`else
    assign wr_word = wr_data;
`endif

    // Write-first: a write landing on the address S1 reads this cycle wins.
    assign s1_word = (wr_fire && (wr_addr == s0_addr_q)) ? wr_word : mem[s0_addr_q];

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem[cnt_q] <= '0;
            end else if (wr_fire) begin
                mem[wr_addr] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            s0_valid_q  <= 1'b0;
            s0_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef MATH_TBL_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_q <= ST_RUN;
                busy_q  <= 1'b0;
            end
        end else if (adv) begin
            s0_valid_q  <= in_valid;
            if (in_valid) begin
                s0_addr_q <= req_addr_d;
            end
            out_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                out_data_q <= s1_word[DATA_W-1:0];
`ifdef MATH_TBL_PARITY_EN
                par_err_q  <= ^s1_word;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
`ifdef MATH_TBL_PARITY_EN
    assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_math_seed_tbl_pipe.sv
// tb/tb_math_seed_tbl_pipe.sv - self-checking bench for math_seed_tbl_pipe
module tb_math_seed_tbl_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [67:0] in_a;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [67:0] out_data;
    logic        wr_en;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [67:0] wr_data;
    logic        busy;
`ifdef MATH_TBL_PARITY_EN
    logic        par_err;
    logic        wr_par_flip;
`endif

    int checks   = 0;
    int failures = 0;
    logic [67:0] model_mem [256];

    typedef struct {
        logic [11:0] e;
        logic [5:0]  m;
        logic [1:0]  mode;
        logic [7:0]  addr;
    } vec_t;
    vec_t vt [11];

    math_seed_tbl_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`ifdef MATH_TBL_PARITY_EN
        .par_err     (par_err),
        .wr_par_flip (wr_par_flip),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [67:0] pat(input logic [7:0] ad);
        return {ad, 52'hC0FFEE1234567, ad};
    endfunction

    function automatic logic [67:0] mk_a(input logic [11:0] e, input logic [5:0] m);
        logic [67:0] r;
        r[31:0]  = $urandom;
        r[63:32] = $urandom;
        r[67:64] = 4'($urandom);
        r[65:54] = e;
        r[53:48] = m;
        return r;
    endfunction

    // Reference index rules in plain arithmetic.
    function automatic int calc_addr(input logic [67:0] a, input logic [1:0] mode);
        int e;
        int m;
        int idx;
        e = int'(a[65:54]);
        m = int'(a[53:48]);
        if (mode == 2'd0)                idx = m;
        else if (mode == 2'd1)           idx = (e % 2) * 32 + m / 2;
        else if (e >= 2044 && e < 2050)  idx = m / (1 << (5 - (e - 2044)));
        else                             idx = 0;
        return idx * 4 + int'(mode);
    endfunction

    task automatic wr(input logic [7:0] ad, input logic [67:0] d, input logic flip);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = ad;
        wr_data = d;
`ifdef MATH_TBL_PARITY_EN
        wr_par_flip = flip;
`else
        if (flip) $display("note: parity flip ignored in this build");
`endif
        model_mem[ad] = d;
        @(negedge clk);
        wr_en = 1'b0;
`ifdef MATH_TBL_PARITY_EN
        wr_par_flip = 1'b0;
`endif
    endtask

    task automatic lookup(input logic [67:0] a, input logic [1:0] m, input logic [67:0] exp, input string nm);
        @(negedge clk);
        in_a      = a;
        in_mode   = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({nm, "_in_ready"}, 68'(in_ready), 68'(1));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({nm, "_lat1"}, 68'(out_valid), 68'(0));
        @(negedge clk);
        #1;
        chk({nm, "_valid"}, 68'(out_valid), 68'(1));
        chk({nm, "_data"}, out_data, exp);
    endtask

    task automatic stream(input int n, input bit stall, input string nm);
        logic [67:0] q[$];
        int  sent = 0;
        int  rcv  = 0;
        int  cyc  = 0;
        bit  need_new = 1'b1;
        while (rcv < n && cyc < 2000) begin
            @(negedge clk);
            if (sent < n) begin
                if (need_new) begin
                    in_a    = mk_a(12'($urandom_range(2040, 2056)), 6'($urandom_range(0, 63)));
                    in_mode = 2'($urandom_range(0, 3));
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = stall ? !(cyc >= 3 && cyc < 6) : ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s_dup actual=%h required=none", nm, out_data);
                end else begin
                    chk({nm, "_data"}, out_data, q.pop_front());
                end
                rcv++;
            end
            if (out_valid && !out_ready) chk({nm, "_stall_in_ready"}, 68'(in_ready), 68'(0));
            need_new = 1'b0;
            if (in_valid && in_ready) begin
                q.push_back(model_mem[calc_addr(in_a, in_mode)]);
                sent++;
                need_new = 1'b1;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({nm, "_count"}, 68'(rcv), 68'(n));
        chk({nm, "_left"}, 68'(q.size()), 68'(0));
    endtask

    initial begin
        int bcnt;
        vt[0]  = '{12'd2046, 6'b101011, 2'd2, 8'h16};
        vt[1]  = '{12'd2000, 6'b101011, 2'd2, 8'h02};
        vt[2]  = '{12'd2050, 6'b001110, 2'd1, 8'h1D};
        vt[3]  = '{12'd2051, 6'b110011, 2'd1, 8'hE5};
        vt[4]  = '{12'd1234, 6'h2A,     2'd0, 8'hA8};
        vt[5]  = '{12'd2044, 6'b100000, 2'd3, 8'h07};
        vt[6]  = '{12'd2049, 6'b101011, 2'd3, 8'hAF};
        vt[7]  = '{12'd2050, 6'b111111, 2'd2, 8'h02};
        vt[8]  = '{12'd2043, 6'b111111, 2'd3, 8'h03};
        vt[9]  = '{12'd2045, 6'b011111, 2'd2, 8'h06};
        vt[10] = '{12'd4095, 6'h3F,     2'd0, 8'hFC};
        for (int i = 0; i < 256; i++) model_mem[i] = '0;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_mode = '0; out_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef MATH_TBL_PARITY_EN
        wr_par_flip = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 68'(out_valid), 68'(0));
        chk("rst_in_ready", 68'(in_ready), 68'(0));
        chk("rst_wr_ready", 68'(wr_ready), 68'(0));
        chk("rst_busy", 68'(busy), 68'(1));
        chk("rst_out_data", out_data, 68'(0));

        @(negedge clk);
        rst  = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (!busy) break;
            bcnt++;
            @(negedge clk);
        end
        chk("busy_cycles", 68'(bcnt), 68'(256));
        chk("run_wr_ready", 68'(wr_ready), 68'(1));

        lookup(mk_a(12'd2046, 6'b101000), 2'd2, 68'(0), "init_zero_a");
        lookup(mk_a(12'd99, 6'h3F), 2'd0, 68'(0), "init_zero_b");

        wr(8'h1D, 68'h5A5, 1'b0);
        lookup(mk_a(12'd2050, 6'b001110), 2'd1, 68'h5A5, "rsqrt_5a5");

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 8'(i);
            wr_data = pat(8'(i));
            model_mem[i] = pat(8'(i));
        end
        @(negedge clk);
        wr_en = 1'b0;

        for (int i = 0; i < 11; i++) begin
            lookup(mk_a(vt[i].e, vt[i].m), vt[i].mode, pat(vt[i].addr), $sformatf("vec%0d", i));
        end

        stream(60, 1'b0, "rand");
        stream(4, 1'b1, "stall4");

        @(negedge clk);
        in_a = mk_a(12'd2000, 6'h15); in_mode = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("byp_in_ready", 68'(in_ready), 68'(1));
        @(negedge clk);
        in_valid = 1'b0; wr_en = 1'b1; wr_addr = 8'h54; wr_data = 68'h7F;
        model_mem[8'h54] = 68'h7F;
        @(negedge clk);
        out_ready = 1'b0; wr_addr = 8'h54; wr_data = 68'h55;
        model_mem[8'h54] = 68'h55;
        #1;
        chk("byp_valid", 68'(out_valid), 68'(1));
        chk("byp_data", out_data, 68'h7F);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("hold_data", out_data, 68'h7F);
        chk("hold_in_ready", 68'(in_ready), 68'(0));
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("hold_release", 68'(out_valid), 68'(0));
        lookup(mk_a(12'd7, 6'h15), 2'd0, 68'h55, "after_hold");

`ifdef MATH_TBL_PARITY_EN
        wr(8'h10, 68'h123, 1'b1);
        lookup(mk_a(12'd7, 6'h04), 2'd0, 68'h123, "par_flip");
        chk("par_err_set", 68'(par_err), 68'(1));
        wr(8'h14, 68'h123, 1'b0);
        lookup(mk_a(12'd7, 6'h05), 2'd0, 68'h123, "par_ok");
        chk("par_err_clr", 68'(par_err), 68'(0));
`endif

        @(negedge clk);
        in_a = mk_a(12'd2046, 6'h2A); in_mode = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_a = mk_a(12'd1000, 6'h11); in_mode = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 68'(out_valid), 68'(1));
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", 68'(out_valid), 68'(0));
        chk("mid_rst_busy", 68'(busy), 68'(1));
        chk("mid_rst_in_ready", 68'(in_ready), 68'(0));
        chk("mid_rst_out_data", out_data, 68'(0));
        rst = 1'b0;
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        chk("reinit_busy", 68'(busy), 68'(0));
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        lookup(mk_a(12'd2050, 6'b001110), 2'd1, 68'(0), "cleared_1d");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
